// File: rtl/ram_dump_uart.sv
// Reads a programmable range of RAM words and serialises them on a UART 8N1 line,
// either as raw bytes (MSB first) or as uppercase ASCII hex followed by CR/LF.
module ram_dump_uart #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned RAM_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              hex_mode,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              done,
  output logic              uart_tx
);

  localparam int unsigned BIN_BYTES = DATA_W / 8;
  localparam int unsigned HEX_CHARS = DATA_W / 4;
  localparam int unsigned IDX_W     = $clog2(HEX_CHARS + 2);
  localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned WAIT_W    = $clog2(RAM_LATENCY + 1);
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned BIT_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    LOAD,
    SEND,
    NEXT,
    FIN
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic                hex_q, hex_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [7:0]          shift_q, shift_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tx_q, tx_d;
  logic [IDX_W-1:0]    last_idx_c;

  // Byte number idx of a word's transmit sequence in the selected output format.
  function automatic logic [7:0] char_at(input logic [DATA_W-1:0] w,
                                         input logic [IDX_W-1:0]  idx,
                                         input logic              hex);
    logic [DATA_W-1:0] sh;
    logic [3:0]        nib;
    sh      = '0;
    nib     = '0;
    char_at = 8'h00;
    if (!hex) begin
      sh      = w >> (DATA_W - 8 - 8 * int'(idx));
      char_at = sh[7:0];
    end else if (int'(idx) < int'(HEX_CHARS)) begin
      sh      = w >> (DATA_W - 4 - 4 * int'(idx));
      nib     = sh[3:0];
      char_at = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else if (int'(idx) == int'(HEX_CHARS)) begin
      char_at = 8'h0D;
    end else begin
      char_at = 8'h0A;
    end
  endfunction

  assign last_idx_c = hex_q ? IDX_W'(HEX_CHARS + 1) : IDX_W'(BIN_BYTES - 1);

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    hex_d      = hex_q;
    word_d     = word_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    wait_d     = wait_q;
    ram_addr_d = ram_addr_q;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          hex_d    = hex_mode;
          remain_d = word_count;
          if (word_count == '0) begin
            state_d = FIN;
          end else begin
            state_d    = READ;
            ram_addr_d = base_addr;
          end
        end
      end
      READ: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == WAIT_W'(RAM_LATENCY - 1)) begin
          state_d = LOAD;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      // First byte comes straight from the RAM bus so the start bit begins next cycle.
      LOAD: begin
        word_d     = ram_data;
        shift_d    = char_at(ram_data, '0, hex_q);
        byte_idx_d = '0;
        bit_idx_d  = '0;
        baud_d     = '0;
        tx_d       = 1'b0;
        state_d    = SEND;
      end
      SEND: begin
        tx_d = tx_q;
        if (baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
          baud_d = '0;
          if (bit_idx_q == BIT_W'(9)) begin
            if (byte_idx_q == last_idx_c) begin
              tx_d    = 1'b1;
              state_d = NEXT;
            end else begin
              byte_idx_d = byte_idx_q + IDX_W'(1);
              shift_d    = char_at(word_q, byte_idx_q + IDX_W'(1), hex_q);
              bit_idx_d  = '0;
              tx_d       = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            tx_d      = (bit_idx_q == BIT_W'(8)) ? 1'b1 : shift_q[bit_idx_q[2:0]];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      NEXT: begin
        remain_d = remain_q - CNT_W'(1);
        if (remain_q == CNT_W'(1)) begin
          state_d = FIN;
        end else begin
          state_d    = READ;
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_en_d = (state_d == READ);
    busy_d  = (state_d != IDLE) && (state_d != FIN);
    done_d  = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      remain_q   <= '0;
      hex_q      <= 1'b0;
      word_q     <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      wait_q     <= '0;
      ram_addr_q <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      hex_q      <= hex_d;
      word_q     <= word_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      wait_q     <= wait_d;
      ram_addr_q <= ram_addr_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_q       <= tx_d;
    end
  end

  assign ram_rd_en = rd_en_q;
  assign ram_addr  = ram_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign uart_tx   = tx_q;

endmodule

// File: tb/tb_ram_dump_uart.sv
// Scoreboard bench for ram_dump_uart: four parameter sets run side by side, each with
// its own RAM model, UART receiver and expected-byte/expected-address queues.
module tb_ram_dump_uart;

  localparam int unsigned AW     = 6;
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned CPB    = 4;
  localparam int unsigned NBLK   = 4;
  localparam int          MAXCYC = 60000;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_byte_t;

  logic clk;
  int   checks;
  int   failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input int b, input string name, input bit ok,
                              input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL blk%0d %s: got %0d (0x%0h) required %0d (0x%0h)", b, name, act, act, req, req);
    end
  endfunction

  genvar g;
  generate
    for (g = 0; g < NBLK; g++) begin : blk
      localparam int unsigned DW  = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 24 : 32;
      localparam int unsigned LAT = (g == 1 || g == 3) ? 3 : 1;
      localparam int unsigned NB  = DW / 8;
      localparam int unsigned NH  = DW / 4;

      logic          rst_n, start, hex_mode, ram_rd_en, busy, done, uart_tx;
      logic [AW-1:0] base_addr, ram_addr;
      logic [CW-1:0] word_count;
      logic [DW-1:0] ram_data;
      logic [DW-1:0] mem [2**AW];
      logic [2:0]    en_pipe;
      logic [AW-1:0] ap0, ap1, ap2;
      exp_byte_t     exp_q[$];
      int            exp_addr[$];
      int            ncyc, done_seen, last_done, busy_seen, rd_seen, first_start;
      bit            fin;

      ram_dump_uart #(
        .DATA_W(DW), .ADDR_W(AW), .CLKS_PER_BIT(CPB), .RAM_LATENCY(LAT)
      ) dut (
        .clk(clk), .reset(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .hex_mode(hex_mode), .ram_rd_en(ram_rd_en),
        .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy), .done(done),
        .uart_tx(uart_tx)
      );

      // RAM with LAT-cycle read latency; output is garbage while a read is in flight.
      always @(posedge clk) begin
        if (!rst_n) begin
          en_pipe <= '0;
        end else begin
          en_pipe <= {en_pipe[1:0], ram_rd_en};
          ap0 <= ram_addr;
          ap1 <= ap0;
          ap2 <= ap1;
          if (en_pipe[LAT-1])
            ram_data <= mem[(LAT == 1) ? ap0 : (LAT == 2) ? ap1 : ap2];
          else if ((en_pipe & 3'((1 << (LAT - 1)) - 1)) != 3'd0)
            ram_data <= DW'($urandom);
        end
      end

      int        rx_pos, idle_run, gap_seen, ea;
      bit        rx_active, have_prev, frame_ok;
      logic [9:0] bits;
      exp_byte_t e_mon;

      // Monitor: counters, read-address scoreboard and UART receiver.
      always @(negedge clk) begin
        ncyc++;
        if (done) begin
          done_seen++;
          last_done = ncyc;
        end
        if (busy) busy_seen++;
        if (ram_rd_en) begin
          rd_seen++;
          if (exp_addr.size() == 0) begin
            chk(g, "unexpected_read", 1'b0, ram_addr, -1);
          end else begin
            ea = exp_addr.pop_front();
            chk(g, "read_addr", ram_addr == AW'(ea), ram_addr, ea);
          end
        end
        if (!rst_n) begin
          rx_active = 1'b0;
          have_prev = 1'b0;
          idle_run  = 0;
        end else begin
          if (!rx_active) begin
            if (uart_tx == 1'b0) begin
              rx_active = 1'b1;
              rx_pos    = 0;
              frame_ok  = 1'b1;
              gap_seen  = have_prev ? idle_run : -1;
              if (first_start < 0) first_start = ncyc;
            end else begin
              idle_run++;
            end
          end
          if (rx_active) begin
            if (rx_pos % CPB == 0) bits[rx_pos / CPB] = uart_tx;
            else if (uart_tx !== bits[rx_pos / CPB]) frame_ok = 1'b0;
            rx_pos++;
            if (rx_pos == 10 * CPB) begin
              rx_active = 1'b0;
              have_prev = 1'b1;
              idle_run  = 0;
              if (exp_q.size() == 0) begin
                chk(g, "unexpected_byte", 1'b0, bits[8:1], -1);
              end else begin
                e_mon = exp_q.pop_front();
                chk(g, "uart_byte", frame_ok && bits[0] == 1'b0 && bits[9] == 1'b1 &&
                    bits[8:1] == e_mon.data, {frame_ok, bits}, {1'b1, 1'b1, e_mon.data, 1'b0});
                if (e_mon.gap >= 0)
                  chk(g, "idle_gap", gap_seen == e_mon.gap, gap_seen, e_mon.gap);
              end
            end
          end
        end
      end

      // Reference model: the byte stream and read addresses a dump must produce.
      task automatic build(input int base, input int cnt, input bit hex);
        string     hx = "0123456789ABCDEF";
        logic [63:0] w;
        exp_byte_t e;
        int        nbytes;
        int        a;
        nbytes = hex ? int'(NH) + 2 : int'(NB);
        for (int i = 0; i < cnt; i++) begin
          a = (base + i) % (2**AW);
          exp_addr.push_back(a);
          w = 64'(mem[a]);
          for (int j = 0; j < nbytes; j++) begin
            if (!hex) e.data = 8'(w >> (8 * (int'(NB) - 1 - j)));
            else if (j < int'(NH)) e.data = hx[int'((w >> (4 * (int'(NH) - 1 - j))) & 64'hF)];
            else if (j == int'(NH)) e.data = 8'h0D;
            else e.data = 8'h0A;
            if (j > 0) e.gap = 0;
            else if (i > 0) e.gap = int'(LAT) + 3;
            else e.gap = -1;
            exp_q.push_back(e);
          end
        end
      endtask

      task automatic launch(input int base, input int cnt, input bit hex, output int t0);
        build(base, cnt, hex);
        done_seen   = 0;
        busy_seen   = 0;
        rd_seen     = 0;
        first_start = -1;
        base_addr   = AW'(base);
        word_count  = CW'(cnt);
        hex_mode    = hex;
        start       = 1'b1;
        @(posedge clk);
        t0 = ncyc;
      endtask

      task automatic run_wait(input int cnt, input int hold, input int ext_at, output int lat);
        int bnd;
        bnd = cnt * ((int'(NH) + 2) * 10 * int'(CPB) + int'(LAT) + 3) + 30;
        lat = -1;
        for (int n = 1; n <= bnd; n++) begin
          @(negedge clk);
          if (n == hold) start = 1'b0;
          if (n == ext_at) start = 1'b1;
          if (n == ext_at + 1) start = 1'b0;
          if (done && lat < 0) lat = n;
          if (lat > 0 && n >= lat + 3 && n > hold) break;
        end
        start = 1'b0;
      endtask

      task automatic dump(input int base, input int cnt, input bit hex, input int ext_at);
        int t0, lat, bl, nb;
        nb = hex ? int'(NH) + 2 : int'(NB);
        bl = cnt * (nb * 10 * int'(CPB) + int'(LAT) + 3);
        launch(base, cnt, hex, t0);
        run_wait(cnt, 1, ext_at, lat);
        chk(g, "done_latency", lat == ((cnt == 0) ? 1 : bl + 1), lat, (cnt == 0) ? 1 : bl + 1);
        chk(g, "done_count", done_seen == 1, done_seen, 1);
        chk(g, "read_count", rd_seen == cnt, rd_seen, cnt);
        chk(g, "bytes_left", exp_q.size() == 0, exp_q.size(), 0);
        if (cnt > 0) begin
          chk(g, "busy_cycles", busy_seen == bl, busy_seen, bl);
          chk(g, "first_start_bit", first_start - t0 == int'(LAT) + 3, first_start - t0, int'(LAT) + 3);
        end else begin
          chk(g, "tx_stays_idle", first_start == -1, first_start, -1);
        end
        exp_q.delete();
        exp_addr.delete();
      endtask

      initial begin
        int t0, lat;
        fin        = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        hex_mode   = 1'b0;
        first_start = -1;
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        mem[5] = DW'(32'hA55A);
        mem[6] = DW'(32'h0102);
        mem[0] = DW'(32'h3F0C);
        repeat (3) @(negedge clk);
        chk(g, "reset_tx", uart_tx == 1'b1, uart_tx, 1);
        chk(g, "reset_busy", busy == 1'b0, busy, 0);
        chk(g, "reset_done", done == 1'b0, done, 0);
        chk(g, "reset_rd_en", ram_rd_en == 1'b0, ram_rd_en, 0);
        chk(g, "reset_addr", ram_addr == '0, ram_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        dump(5, 2, 1'b0, 50);
        dump(0, 1, 1'b1, -1);
        dump(63, 3, 1'b0, -1);
        dump(0, 0, 1'b0, -1);

        if (g == 0) begin
          // start held for four edges: accepted at edges 0 and 2, ignored during FIN
          launch(0, 0, 1'b0, t0);
          run_wait(0, 4, -1, lat);
          chk(g, "held_first_done", lat == 1, lat, 1);
          chk(g, "held_done_count", done_seen == 2, done_seen, 2);
          chk(g, "held_second_done", last_done - t0 == 3, last_done - t0, 3);
          chk(g, "held_no_reads", rd_seen == 0, rd_seen, 0);

          // reset in the middle of data bit 1 of the first byte
          launch(5, 1, 1'b0, t0);
          @(negedge clk);
          start = 1'b0;
          repeat (12) @(negedge clk);
          rst_n = 1'b0;
          #1;
          chk(g, "midreset_tx", uart_tx == 1'b1, uart_tx, 1);
          chk(g, "midreset_busy", busy == 1'b0, busy, 0);
          chk(g, "midreset_rd_en", ram_rd_en == 1'b0, ram_rd_en, 0);
          exp_q.delete();
          exp_addr.delete();
          repeat (4) @(negedge clk);
          rst_n = 1'b1;
          repeat (3) @(negedge clk);
          chk(g, "midreset_no_done", done_seen == 0, done_seen, 0);
          dump(5, 2, 1'b0, -1);

          dump(10, 2**AW, 1'b0, -1);
        end

        for (int r = 0; r < 5; r++) begin
          for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
          dump(int'($urandom_range(0, 2**AW - 1)), int'($urandom_range(1, 4)),
               1'($urandom_range(0, 1)), -1);
        end
        fin = 1'b1;
      end
    end
  endgenerate

  initial begin
    bit all_fin;
    all_fin = 1'b0;
    for (int n = 0; n < MAXCYC && !all_fin; n++) begin
      @(negedge clk);
      all_fin = blk[0].fin && blk[1].fin && blk[2].fin && blk[3].fin;
    end
    if (!all_fin) begin
      checks++;
      failures++;
      $display("FAIL timeout: blocks finished %0d%0d%0d%0d required 1111",
               blk[0].fin, blk[1].fin, blk[2].fin, blk[3].fin);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
